// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder with programmable latency.
//   Accepts one load or store at a time and holds it for LATENCY wait cycles.
//   It then performs the access on an internal word array and pulses
//   data_ready_o for one cycle.
// Ports:
//   clk_i              rising-edge clock
//   rst_ni             asynchronous active-low reset (array is not cleared)
//   data_read_valid_i  load request
//   data_write_valid_i store request
//   data_write_byte_i  store byte enables, bit i -> lane [8i+7:8i]
//   data_write_i       lane-aligned store data
//   data_addr_i        byte address, bits [1:0] ignored for indexing
//   data_read_o        whole-word load result, held until the next completed load
//   data_ready_o       one-cycle completion strobe
//   busy_o             high while a request is held
//   fault_o            error flag, meaningful only while data_ready_o=1
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        data_read_valid_i,
   input  logic        data_write_valid_i,
   input  logic [3:0]  data_write_byte_i,
   input  logic [31:0] data_write_i,
   input  logic [31:0] data_addr_i,
   output logic [31:0] data_read_o,
   output logic        data_ready_o,
   output logic        busy_o,
   output logic        fault_o
);
   localparam int unsigned AW   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_e;
   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        accept;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  be_q;
   logic        rd_q, wr_q, fault_q;
   logic [31:0] mem [DEPTH_WORDS];
   logic [32:0] off;
   logic        in_range, illegal;
   logic [AW-1:0] idx;
   logic        unused_ok;
   // 33-bit offset so the upper bound compare cannot wrap.
   assign off       = {1'b0, addr_q} - {1'b0, BASE_ADDR};
   assign in_range  = (addr_q >= BASE_ADDR) && (off < SPAN);
   assign idx       = off[AW+1:2];
   assign illegal   = rd_q & wr_q;
   assign unused_ok = ^{off[32:AW+2], off[1:0]};
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   // WAIT holds for LATENCY cycles: it leaves on the edge where the count is 1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: if (data_read_valid_i || data_write_valid_i) begin
            accept  = 1'b1;
            cnt_d   = 4'(LATENCY);
            state_d = (LATENCY > 0) ? WAIT : ACCESS;
         end
         WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? ACCESS : WAIT;
         end
         ACCESS: state_d = RESP;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      busy_o       = state_q != IDLE;
      data_ready_o = state_q == RESP;
      fault_o      = (state_q == RESP) & fault_q;
      data_read_o  = rdata_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         fault_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= data_addr_i;
            wdata_q <= data_write_i;
            be_q    <= data_write_byte_i;
            rd_q    <= data_read_valid_i;
            wr_q    <= data_write_valid_i;
         end
         if (state_q == ACCESS) begin
            fault_q <= illegal | ~in_range;
            if (rd_q && !wr_q) rdata_q <= in_range ? mem[idx] : '0;
         end
      end
   end
   // Array has no reset so its contents survive rst_ni.
   always_ff @(posedge clk_i) begin
      if (state_q == ACCESS && wr_q && !rd_q && in_range)
         for (int b = 0; b < 4; b++)
            if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
   end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the core's data-memory request interface. The core drives a load or store request with address, write data and byte enables. This block accepts one request at a time and waits a programmable number of cycles. It then performs the byte-lane write or the word read on an internal word array and returns a one-cycle completion strobe, with read data for loads. It sits between the control/ALU datapath and the data-memory storage.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, minimum 4.
BASE_ADDR, 32'h00020000, byte address of word 0; must be 4-byte aligned.
LATENCY, 2, wait cycles between accept and completion; range 0..15.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
data_read_valid  input  1  load request
data_write_valid  input  1  store request
data_write_byte  input  4  store byte enables; bit i selects lane [8i+7:8i]
data_write  input  32  store data, lane-aligned
data_addr  input  32  byte address; bits [1:0] are ignored for indexing
data_read  output  32  load result, whole word
data_ready  output  1  one-cycle completion strobe
busy  output  1  high while a request is held
fault  output  1  error flag for the completing request; valid only while data_ready=1

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, data_read=0, data_ready=0, busy=0, fault=0, wait counter=0. Array contents are not cleared and are retained across reset.
- FSM states:
  - IDLE:
    - If data_read_valid or data_write_valid is sampled high at a clock edge, latch addr, wdata, byte enables and request type, set busy=1, and load counter=LATENCY.
    - Next state is WAIT if LATENCY>0, else ACCESS.
  - WAIT: decrement counter each cycle; go to ACCESS when the counter reaches 1.
  - ACCESS: perform the access at the next edge and go to RESP.
  - RESP: data_ready=1 for exactly one cycle; busy drops at the end of RESP; next state is IDLE.
- Latency: a request accepted at edge k gives data_ready high during cycle k+LATENCY+2, measured from that edge.
- Range check: in range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS. Word index = (addr-BASE_ADDR)>>2. Use 33-bit compare so the upper bound cannot wrap.
- Store, in range:
  - Only lanes with a 1 in data_write_byte are updated; other lanes keep their old value.
  - data_write_byte=0 is a legal no-op and completes with fault=0.
  - data_read is unchanged by a store.
- Load, in range: data_read is set to the whole addressed word in RESP and held until the next completed load. The requester does the lane select and sign extension.
- Out of range: no array write; a load returns data_read=0; fault=1 with data_ready.
- data_read_valid and data_write_valid both high at accept: the request is treated as illegal. No array access is made, fault=1, and data_read is unchanged.
- Request inputs are ignored while busy=1; only the values latched at accept are used.
- The requester must drop its valid in the cycle data_ready=1. A valid still high in the first IDLE cycle after RESP is accepted as a new request.
- Reset asserted mid-request aborts it: no array write happens unless the ACCESS edge already occurred, and no data_ready is issued.

Test Plan:
- Word store then load, LATENCY=2:
  - Store addr=0x00020010, be=4'b1111, data=0xDEADBEEF: data_ready exactly 4 cycles after accept, fault=0.
  - Load of the same addr: data_read=0xDEADBEEF with data_ready.
- Byte-lane merge:
  - Preload 0x11223344 at 0x00020020, then store be=4'b0100, data=0x00AA0000.
  - Load returns 0x11AA3344.
- Address bounds, DEPTH_WORDS=1024:
  - Load at 0x00020FFC (last word) gives fault=0.
  - Load at 0x00021000 gives fault=1, data_read=0.
  - Load at 0x0001FFFC gives fault=1.
  - Store at 0xFFFFFFFC gives fault=1 and no array change.
- Both valids high at 0x00020000 gives fault=1 and a later load shows the word unchanged. busy=1 from accept to the end of RESP, and a second request presented while busy is ignored.
- Reset mid-request: assert reset=0 one cycle after accepting a store of 0xCAFEF00D.
  - All outputs are 0 immediately and no data_ready is issued.
  - After release, a load shows the prior word intact.
- LATENCY=0 build: data_ready 2 cycles after accept; back-to-back requests complete every 3 cycles.
